// File: rtl/matrix_pkg.sv
// Shared constants and helpers for the double-buffered matrix scanner.
// Scan state encoding and the active-low row-select helper live here.
package matrix_pkg;

  localparam int ROWS_DEF     = 8;
  localparam int COLS_DEF     = 16;
  localparam int PWM_BITS_DEF = 2;
  localparam int RW_DEF       = 3;

  localparam logic [0:0] ST_DEAD   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // One bit of an active-low one-hot row select.
  function automatic logic row_sel_n(
    input int idx,
    input int row
  );
    return idx != row;
  endfunction

endpackage

// File: rtl/matrix_fb_bank.sv
// Dual-bank row bitmap store: one write port into the selected bank,
// combinational read of one row from the other selected bank.
module matrix_fb_bank
  import matrix_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF,
  parameter int RW   = RW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en_i,
  input  logic            wr_bank_i,
  input  logic [RW-1:0]   wr_row_i,
  input  logic [COLS-1:0] wr_data_i,
  input  logic            rd_bank_i,
  input  logic [RW-1:0]   rd_row_i,
  output logic [COLS-1:0] rd_data_o
);

  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [COLS-1:0] mem_q [2][ROWS];
  logic            wr_ok;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;

  assign wr_ok  = wr_en_i &&
                  ({1'b0, wr_row_i} < (RW+1)'(ROWS));
  assign wr_idx = AW'(wr_row_i);
  assign rd_idx = AW'(rd_row_i);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          mem_q[b][r] <= '0;
        end
      end
    end else if (wr_ok) begin
      mem_q[wr_bank_i][wr_idx] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_bank_i][rd_idx];

endmodule

// File: rtl/matrix_fb_scanner.sv
// Double-buffered LED dot-matrix scan driver with dead-time slot,
// per-row PWM brightness and frame-synchronous buffer swap.
module matrix_fb_scanner
  import matrix_pkg::*;
#(
  parameter int ROWS     = ROWS_DEF,
  parameter int COLS     = COLS_DEF,
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int RW       = RW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [RW-1:0]       wr_row,
  input  logic [COLS-1:0]     wr_data,
  input  logic                swap_req,
  output logic                swap_ack,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                blank,
  output logic [ROWS-1:0]     row_out,
  output logic [COLS-1:0]     col_out,
  output logic                frame_start
);

  localparam int PW = PWM_BITS + 1;
  localparam logic [PW-1:0] LAST_PH = PW'(2 ** PWM_BITS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  logic [0:0]      state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [RW-1:0]   row_q, row_d;
  logic            bank_q, bank_d;
  logic            pend_q, pend_d;
  logic            ack_q, ack_d;
  logic            fs_q, fs_d;
  logic [ROWS-1:0] row_out_q, row_out_d;
  logic [COLS-1:0] col_q, col_d;
  logic [COLS-1:0] rd_data;
  logic            last_ph;
  logic            wrap;

  matrix_fb_bank #(
    .ROWS (ROWS),
    .COLS (COLS),
    .RW   (RW)
  ) u_bank (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_en),
    .wr_bank_i (~bank_q),
    .wr_row_i  (wr_row),
    .wr_data_i (wr_data),
    .rd_bank_i (bank_d),
    .rd_row_i  (row_d),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    row_d   = row_q;
    bank_d  = bank_q;
    last_ph = (state_q == ST_ACTIVE) && (phase_q == LAST_PH);
    wrap    = (row_q == LAST_ROW);
    unique case (1'b1)
      (state_q == ST_DEAD): begin
        state_d = ST_ACTIVE;
        phase_d = PW'(1);
      end
      last_ph: begin
        state_d = ST_DEAD;
        phase_d = '0;
        row_d   = wrap ? '0 : row_q + RW'(1);
        bank_d  = bank_q ^ (wrap & ack_q);
      end
      default: begin
        phase_d = phase_q + PW'(1);
      end
    endcase
  end

  // Ack is raised for the last active slot of the frame; the bank
  // flips at the end of that slot, so the next row 0 is clean.
  always_comb begin
    pend_d = (pend_q & ~ack_q) | swap_req;
    ack_d  = (state_d == ST_ACTIVE) && (phase_d == LAST_PH) &&
             (row_d == LAST_ROW) && (pend_q | swap_req);
    fs_d   = (state_d == ST_DEAD) && (row_d == '0);
  end

  always_comb begin
    row_out_d = '1;
    col_d     = '0;
    if (state_d == ST_ACTIVE) begin
      for (int i = 0; i < ROWS; i++) begin
        row_out_d[i] = row_sel_n(i, int'(row_d));
      end
      if (!blank &&
          (phase_d <= PW'(brightness) + PW'(1))) begin
        col_d = rd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_DEAD;
      phase_q   <= '0;
      row_q     <= '0;
      bank_q    <= 1'b0;
      pend_q    <= 1'b0;
      ack_q     <= 1'b0;
      fs_q      <= 1'b0;
      row_out_q <= '1;
      col_q     <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      row_q     <= row_d;
      bank_q    <= bank_d;
      pend_q    <= pend_d;
      ack_q     <= ack_d;
      fs_q      <= fs_d;
      row_out_q <= row_out_d;
      col_q     <= col_d;
    end
  end

  assign swap_ack    = ack_q;
  assign frame_start = fs_q;
  assign row_out     = row_out_q;
  assign col_out     = col_q;

endmodule

// File: tb/tb_matrix_fb_scanner.sv
// Directed bench for matrix_fb_scanner (8 rows x 16 cols, 2 PWM bits).
// Expected outputs come from a cycle position model and bench bitmaps.
module tb_matrix_fb_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_row = 4'd0;
  logic [15:0] wr_data = 16'h0;
  logic        swap_req = 1'b0;
  logic        swap_ack;
  logic [1:0]  brightness = 2'd3;
  logic        blank = 1'b0;
  logic [7:0]  row_out;
  logic [15:0] col_out;
  logic        frame_start;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          fb = 0;
  bit          exp_swap = 1'b0;
  logic [15:0] mem [2][8];

  matrix_fb_scanner #(
    .ROWS     (8),
    .COLS     (16),
    .PWM_BITS (2),
    .RW       (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_row      (wr_row),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .brightness  (brightness),
    .blank       (blank),
    .row_out     (row_out),
    .col_out     (col_out),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d: observed %h expected %h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 8; r++)
        mem[b][r] = 16'h0;
    fb = 0;
    exp_swap = 1'b0;
  endtask

  task automatic tick();
    int p;
    int r;
    logic [7:0]  e_row;
    logic [15:0] e_col;
    logic        e_ack;
    @(posedge clk);
    if (wr_en && wr_row < 4'd8)
      mem[1-fb][wr_row[2:0]] = wr_data;
    if (cyc % 5 == 4 && (cyc / 5) % 8 == 7 && exp_swap) begin
      fb = 1 - fb;
      exp_swap = 1'b0;
    end
    cyc++;
    #1;
    p = cyc % 5;
    r = (cyc / 5) % 8;
    e_row = (p == 0) ? 8'hFF : ~(8'h01 << r);
    e_col = (p == 0 || blank || p > int'(brightness) + 1)
            ? 16'h0 : mem[fb][r];
    e_ack = (p == 4 && r == 7) ? exp_swap : 1'b0;
    chk("row_out", 32'(row_out), 32'(e_row));
    chk("col_out", 32'(col_out), 32'(e_col));
    chk("frame_start", 32'(frame_start), 32'(p == 0 && r == 0));
    chk("swap_ack", 32'(swap_ack), 32'(e_ack));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int row, input int ph);
    for (int k = 0; k < 41; k++) begin
      if (cyc % 5 == ph && (cyc / 5) % 8 == row) break;
      tick();
    end
    chk("run_to_pos", 32'(cyc % 5 + 8 * ((cyc / 5) % 8)),
        32'(ph + 8 * row));
  endtask

  initial begin
    clear_model();
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_row_out", 32'(row_out), 32'hFF);
    chk("rst_col_out", 32'(col_out), 32'h0);
    chk("rst_swap_ack", 32'(swap_ack), 32'h0);
    chk("rst_frame_start", 32'(frame_start), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;

    // two blank frames
    run(80);

    // back[3]=A5A5, ignored row 9, swap at frame end
    brightness = 2'd3;
    wr_en = 1'b1; wr_row = 4'd3; wr_data = 16'hA5A5;
    tick();
    wr_row = 4'd9; wr_data = 16'hFFFF;
    tick();
    wr_en = 1'b0;
    swap_req = 1'b1;
    exp_swap = 1'b1;
    run_to(7, 4);
    wr_en = 1'b1; wr_row = 4'd0; wr_data = 16'h0001;
    swap_req = 1'b0;
    tick();
    wr_en = 1'b0;
    run(39);

    // PWM widths, mid-row brightness change, blank
    brightness = 2'd0;
    run(40);
    brightness = 2'd1;
    run(40);
    brightness = 2'd2;
    run(22);
    blank = 1'b1;
    run(10);
    blank = 1'b0;
    brightness = 2'd3;
    run(8);

    // mid-frame swap request: no tearing
    wr_en = 1'b1; wr_row = 4'd5; wr_data = 16'h00FF;
    tick();
    wr_row = 4'd7; wr_data = 16'hFFFF;
    tick();
    wr_en = 1'b0;
    run_to(2, 2);
    swap_req = 1'b1;
    exp_swap = 1'b1;
    run_to(7, 4);
    swap_req = 1'b0;
    run(41);

    // async reset mid row 5
    run_to(5, 2);
    #2 reset = 1'b0;
    #1;
    chk("midrst_row_out", 32'(row_out), 32'hFF);
    chk("midrst_col_out", 32'(col_out), 32'h0);
    chk("midrst_swap_ack", 32'(swap_ack), 32'h0);
    chk("midrst_frame_start", 32'(frame_start), 32'h0);
    clear_model();
    @(posedge clk);
    #1;
    chk("inrst_row_out", 32'(row_out), 32'hFF);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    run(45);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
